spm_driver: RTL

Operand sequencer and product collector for the serial-parallel multiplier `spm`. It accepts a pair of parallel operands through a valid/ready handshake and holds `x` on the multiplier's parallel input. It shifts `y` LSB-first into the multiplier's serial input and deserializes the serial product `p` into a 2N-bit word. The finished product is presented through a second valid/ready handshake.

---
 rtl/spm_driver_pkg.sv | 13 +
 rtl/spm_driver_if.sv | 22 ++
 rtl/spm_sipo.sv | 19 +
 rtl/spm_driver.sv | 104 ++++++++++
 4 files changed

// File: rtl/spm_driver_pkg.sv
// Shared types and default sizing for the spm_driver operand sequencer.
package spm_driver_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    localparam int N_DEF     = 8;
    localparam int P_LAT_DEF = 0;

    function automatic int cnt_w(input int n, input int p_lat);
        return $clog2(2 * n + p_lat + 1);
    endfunction

    localparam int CNT_W = cnt_w(N_DEF, P_LAT_DEF);
endpackage

// File: rtl/spm_driver_if.sv
// Operand and product handshakes between a client (master) and spm_driver (slave).
interface spm_driver_if #(
    parameter int N = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x_in;
    logic [N-1:0]   y_in;
    logic [2*N-1:0] prod;
    logic           prod_valid;
    logic           prod_ready;

    modport master (
        output in_valid, x_in, y_in, prod_ready,
        input  in_ready, prod, prod_valid
    );

    modport slave (
        input  in_valid, x_in, y_in, prod_ready,
        output in_ready, prod, prod_valid
    );
endinterface

// File: rtl/spm_sipo.sv
// Serial-in/parallel-out register; new bits enter at the MSB and move toward bit 0.
module spm_sipo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end
endmodule

// File: rtl/spm_driver.sv
// Feeds x/y into the serial-parallel multiplier and collects its serial product.
// Define SPM_DRIVER_SIGNED_Y_EN to sign-extend y; by default y is zero-extended.
module spm_driver
    import spm_driver_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int P_LAT = P_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    spm_driver_if.slave  bus,
    output logic         mc_rst,
    output logic [N-1:0] mc_x,
    output logic         mc_y,
    input  logic         mc_p
);
    localparam int            CW   = cnt_w(N, P_LAT);
    localparam logic [CW-1:0] LAST = CW'(2 * N + P_LAT - 1);

    state_t         state;
    logic [2*N-1:0] ysr;
    logic [2*N-1:0] y_ext;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           samp;
    logic           shift_en;

`ifdef SPM_DRIVER_SIGNED_Y_EN
    assign y_ext = {{N{bus.y_in[N-1]}}, bus.y_in};
`else
    assign y_ext = {{N{1'b0}}, bus.y_in};
`endif

    // Product bits only become meaningful once the multiplier pipeline has filled.
    generate
        if (P_LAT == 0) begin : g_nolat
            assign samp = 1'b1;
        end else begin : g_lat
            assign samp = (cnt >= CW'(P_LAT));
        end
    endgenerate

    assign accept   = (state == IDLE) && bus.in_valid && bus.in_ready;
    assign shift_en = (state == SHIFT) && samp;
    assign mc_y     = ysr[0];

    spm_sipo #(.W(2 * N)) u_prod (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shift_en),
        .din (mc_p),
        .q   (bus.prod)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            bus.in_ready   <= 1'b0;
            bus.prod_valid <= 1'b0;
            mc_rst         <= 1'b1;
            mc_x           <= '0;
            ysr            <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mc_rst       <= 1'b0;
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        mc_x         <= bus.x_in;
                        ysr          <= y_ext;
                        bus.in_ready <= 1'b0;
                        mc_rst       <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    mc_rst <= 1'b0;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    // Top bit already holds the extension bit, so it refills itself.
                    ysr <= {ysr[2*N-1], ysr[2*N-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        ysr            <= '0;
                        bus.prod_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.prod_ready) begin
                        bus.prod_valid <= 1'b0;
                        bus.in_ready   <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
